// File: rtl/instr_encoder_queue.sv
// Packs decoded RV32 fields into 32-bit instruction words and buffers them in a
// small FIFO for the debug/boot injector; flags immediates the format cannot hold.
module instr_encoder_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_format,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic                       out_error,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Handshake: a side transfers on a rising edge where its valid and ready are
  // both high; in_ready depends only on occupancy, never on out_ready.

  // ---------------------------------------------------------------- encoder
  logic [31:0] enc_word;
  logic        enc_error;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  // An immediate fits an N-bit signed field when every bit above it copies its sign.
  assign fits_12 = (in_imm[31:11] == {21{in_imm[11]}});
  assign fits_13 = (in_imm[31:12] == {20{in_imm[12]}});
  assign fits_21 = (in_imm[31:20] == {12{in_imm[20]}});

  always_comb begin
    enc_word  = 32'h0000_0013;
    enc_error = 1'b1;
    case (in_format)
      FMT_R: begin
        enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_error = 1'b0;
      end
      FMT_I: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_error = !fits_12;
      end
      FMT_S: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_error = !fits_12;
      end
      FMT_B: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_error = !fits_13 || in_imm[0];
      end
      FMT_U: begin
        enc_word  = {in_imm[31:12], in_rd, in_opcode};
        enc_error = (in_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_error = !fits_21 || in_imm[0];
      end
      default: begin
        enc_word  = 32'h0000_0013;
        enc_error = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------ queue
  logic [32:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [32:0]   head;

  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] remaining;
  logic [CW-1:0] count_next;

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  assign rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign remaining  = count - CW'(pop);
  assign count_next = remaining + CW'(push);

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {enc_error, enc_word};
  end

  // The head register holds whatever the entry at rd_next will be after this
  // edge: an older stored entry, the word being pushed into an empty queue, or 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (remaining != '0) head <= mem[rd_next];
      else if (push)       head <= {enc_error, enc_word};
      else                 head <= '0;
    end
  end

  assign out_instr = head[31:0];
  assign out_error = head[32];
  assign out_count = count;

endmodule
